// File: rtl/audio_sequencer.sv
// rtl/audio_sequencer.sv - 16-step audio control-word sequencer driving AudioControlRegister
// Plays (word, duration) steps at a prescaled tick rate with optional loop, mute gap and stop.
module audio_sequencer #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int GAP_TICKS   = 0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic [3:0]  AudioControlRegister,
  output logic        Playing,
  output logic [3:0]  StepIndex,
  output logic        Done
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int GW  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [15:0]   mem_q [16];
  logic [1:0]    state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [3:0]    out_q, out_d;
  logic          done_q, done_d;
  logic          playing_q, playing_d;
  logic          loop_q, loop_d;
  logic [3:0]    last_q, last_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;

  logic        ctrl_wr, cmd_stop, cmd_start, tick, adv, fin;
  logic [15:0] entry;

  // Program memory is deliberately left unreset; entries are consumed only at LOAD.
  always_ff @(posedge CLK) begin
    if (wr_en && !wr_addr[4]) begin
      mem_q[wr_addr[3:0]] <= wr_data;
    end
  end

  assign entry     = mem_q[step_q];
  assign ctrl_wr   = wr_en && (wr_addr == 5'd16);
  assign cmd_stop  = ctrl_wr && wr_data[1];
  assign cmd_start = ctrl_wr && wr_data[0] && !wr_data[1];
  assign tick      = (presc_q == PW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    out_d   = out_q;
    done_d  = 1'b0;
    loop_d  = loop_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    adv     = 1'b0;
    fin     = 1'b0;
    presc_d = '0;
    if (state_q == ST_PLAY || state_q == ST_GAP) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    case (state_q)
      ST_LOAD: begin
        if (entry[11:0] == 12'd0) begin
          fin = 1'b1;
        end else begin
          out_d   = entry[15:12];
          cnt_d   = entry[11:0];
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          cnt_d = cnt_q - 12'd1;
          if (cnt_q == 12'd1) begin
            if (GAP_TICKS > 0) begin
              out_d   = 4'd0;
              gap_d   = GW'(GAP_TICKS);
              state_d = ST_GAP;
            end else begin
              adv = 1'b1;
            end
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          gap_d = gap_q - GW'(1);
          if (gap_q == GW'(1)) begin
            adv = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (adv) begin
      if (step_q != last_q) begin
        step_d  = step_q + 4'd1;
        state_d = ST_LOAD;
      end else if (loop_q) begin
        step_d  = 4'd0;
        state_d = ST_LOAD;
      end else begin
        fin = 1'b1;
      end
    end

    if (fin) begin
      done_d  = 1'b1;
      out_d   = 4'd0;
      state_d = ST_IDLE;
    end

    // Commands override whatever the sequencer was doing this cycle; stop beats start.
    if (cmd_stop) begin
      state_d = ST_IDLE;
      out_d   = 4'd0;
      done_d  = 1'b0;
      presc_d = '0;
    end else if (cmd_start) begin
      state_d = ST_LOAD;
      step_d  = 4'd0;
      done_d  = 1'b0;
      presc_d = '0;
    end

    if (ctrl_wr) begin
      loop_d = wr_data[2];
      last_d = wr_data[7:4];
    end

    playing_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      step_q    <= 4'd0;
      out_q     <= 4'd0;
      done_q    <= 1'b0;
      playing_q <= 1'b0;
      loop_q    <= 1'b0;
      last_q    <= 4'd15;
      presc_q   <= '0;
      cnt_q     <= 12'd0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      out_q     <= out_d;
      done_q    <= done_d;
      playing_q <= playing_d;
      loop_q    <= loop_d;
      last_q    <= last_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
    end
  end

  assign AudioControlRegister = out_q;
  assign Playing              = playing_q;
  assign StepIndex            = step_q;
  assign Done                 = done_q;

endmodule

// File: tb/tb_audio_sequencer.sv
// tb/tb_audio_sequencer.sv - randomized bench for audio_sequencer with a cycle-countdown reference model
// Two instances (no gap, GAP_TICKS=2) share stimulus; each is checked every cycle against the model.
module tb_audio_sequencer;

  localparam int DIV = 10;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [15:0] wr_data = 16'd0;
  logic [3:0]  acr0, idx0, acr1, idx1;
  logic        ply0, dn0, ply1, dn1;

  audio_sequencer #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .GAP_TICKS(0)) dut0 (
    .CLK(CLK), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .AudioControlRegister(acr0), .Playing(ply0), .StepIndex(idx0), .Done(dn0));

  audio_sequencer #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .GAP_TICKS(2)) dut1 (
    .CLK(CLK), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .AudioControlRegister(acr1), .Playing(ply1), .StepIndex(idx1), .Done(dn1));

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: 0 idle, 1 load, 2 holding a word, 3 muted gap; rem counts clock cycles left.
  int          m_st[2], m_rem[2], m_step[2], m_out[2], m_last[2];
  bit          m_done[2], m_loop[2];
  int          gapt[2] = '{0, 2};
  logic [15:0] m_mem[16];

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_rem[k] = 0; m_step[k] = 0; m_out[k] = 0;
      m_done[k] = 1'b0; m_loop[k] = 1'b0; m_last[k] = 15;
    end
  endtask

  task automatic m_finish(input int k);
    m_done[k] = 1'b1; m_out[k] = 0; m_st[k] = 0;
  endtask

  task automatic m_advance(input int k);
    if (m_step[k] != m_last[k]) begin
      m_step[k] = m_step[k] + 1; m_st[k] = 1;
    end else if (m_loop[k]) begin
      m_step[k] = 0; m_st[k] = 1;
    end else begin
      m_finish(k);
    end
  endtask

  task automatic m_tick(input int k, input bit ctrl, input logic [15:0] d);
    logic [15:0] e;
    m_done[k] = 1'b0;
    if (ctrl && d[1]) begin
      m_st[k] = 0; m_out[k] = 0;
    end else if (ctrl && d[0]) begin
      m_st[k] = 1; m_step[k] = 0;
    end else begin
      case (m_st[k])
        1: begin
          e = m_mem[m_step[k]];
          if (e[11:0] == 12'd0) m_finish(k);
          else begin
            m_out[k] = int'(e[15:12]); m_rem[k] = int'(e[11:0]) * DIV; m_st[k] = 2;
          end
        end
        2: begin
          m_rem[k] = m_rem[k] - 1;
          if (m_rem[k] == 0) begin
            if (gapt[k] > 0) begin
              m_out[k] = 0; m_rem[k] = gapt[k] * DIV; m_st[k] = 3;
            end else m_advance(k);
          end
        end
        3: begin
          m_rem[k] = m_rem[k] - 1;
          if (m_rem[k] == 0) m_advance(k);
        end
        default: ;
      endcase
    end
    if (ctrl) begin
      m_loop[k] = d[2]; m_last[k] = int'(d[7:4]);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      if (Reset) m_reset();
      else begin
        for (int k = 0; k < 2; k++) m_tick(k, wr_en && (wr_addr == 5'd16), wr_data);
        if (wr_en && !wr_addr[4]) m_mem[wr_addr[3:0]] = wr_data;
      end
    end
  end

  task automatic check_dut(input int k, input logic [3:0] a, input logic p, input logic [3:0] i, input logic dn);
    vectors++;
    if (int'(a) != m_out[k] || p != (m_st[k] != 0) || int'(i) != m_step[k] || dn != m_done[k]) begin
      miscompares++;
      $display("FAIL model dut%0d t=%0t acr/play/idx/done got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               k, $time, a, p, i, dn, m_out[k], (m_st[k] != 0), m_step[k], m_done[k]);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en && !Reset) begin
        check_dut(0, acr0, ply0, idx0, dn0);
        check_dut(1, acr1, ply1, idx1, dn1);
      end
    end
  end

  task automatic lit(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    @(negedge CLK);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge CLK);
    #1 wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  int hist[2][16];
  int dcnt[2], didx[2], pcnt[2], pz[2], wraps[2], fst[2];

  task automatic measure(input int n);
    int prev[2];
    logic [3:0] a, i;
    logic p, dn;
    prev[0] = int'(idx0); prev[1] = int'(idx1);
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++) hist[k][w] = 0;
      dcnt[k] = 0; didx[k] = -1; pcnt[k] = 0; pz[k] = 0; wraps[k] = 0; fst[k] = -1;
    end
    for (int j = 0; j < n; j++) begin
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        a = k ? acr1 : acr0; i = k ? idx1 : idx0; p = k ? ply1 : ply0; dn = k ? dn1 : dn0;
        if (j == 0) fst[k] = int'(a);
        hist[k][a]++;
        if (dn) begin dcnt[k]++; didx[k] = int'(i); end
        if (p) pcnt[k]++;
        if (p && a == 4'd0) pz[k]++;
        if (prev[k] == 1 && i == 4'd0) wraps[k]++;
        prev[k] = int'(i);
      end
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((m_st[0] != 0 || m_st[1] != 0) && w < 3000) begin
      @(negedge CLK); w++;
    end
    vectors++;
    if (w >= 3000) begin
      miscompares++;
      $display("FAIL idle_timeout got %0d cycles want <3000", w);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    int op;
    repeat (2) @(negedge CLK);
    lit("reset_acr", int'(acr0), 0); lit("reset_play", int'(ply0), 0);
    lit("reset_idx", int'(idx1), 0); lit("reset_done", int'(dn1), 0);
    Reset = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 16; i++) wr(5'(i), {4'(i), 12'd1});

    // One-shot
    wr(5'd0, 16'h8002); wr(5'd1, 16'h3001);
    wr(5'd16, 16'h0011);
    measure(40);
    lit("oneshot_8_cycles", hist[0][8], 21);
    lit("oneshot_3_cycles", hist[0][3], 10);
    lit("oneshot_done", dcnt[0], 1);
    lit("oneshot_playing_end", int'(ply0), 0);

    // Loop, three passes, then stop mid-play
    wr(5'd16, 16'h0015);
    measure(97);
    lit("loop_8_cycles", hist[0][8], 63);
    lit("loop_3_cycles", hist[0][3], 33);
    lit("loop_no_done", dcnt[0], 0);
    lit("loop_wraps", wraps[0], 3);
    wr(5'd16, 16'h0002);
    lit("stop_acr", int'(acr0), 0);
    lit("stop_play", int'(ply0), 0);
    measure(5);
    lit("stop_no_done", dcnt[0] + dcnt[1], 0);

    // Gap and end marker
    wr(5'd0, 16'h5001); wr(5'd1, 16'h0000);
    wr(5'd16, 16'h0031);
    measure(40);
    lit("gap_5_cycles", hist[1][5], 10);
    lit("gap_muted_playing", pz[1], 22);
    lit("gap_done", dcnt[1], 1);
    lit("gap_done_idx", didx[1], 1);

    // Start and stop together in IDLE
    wr(5'd16, 16'h0013);
    measure(5);
    lit("startstop_play0", pcnt[0], 0);
    lit("startstop_play1", pcnt[1], 0);

    // Live edit of step 1, then restart during step 1
    wr(5'd0, 16'h8002); wr(5'd1, 16'h3001);
    wr(5'd16, 16'h0011);
    idle(5);
    wr(5'd1, 16'hC001);
    measure(18);
    lit("edit_c_cycles", hist[0][12], 2);
    wr(5'd16, 16'h0011);
    measure(22);
    lit("restart_first_word", fst[0], 12);
    lit("restart_8_cycles", hist[0][8], 21);
    wait_idle();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        d = 16'($urandom);
        d[11:0] = 12'($urandom_range(0, 3));
        wr(5'($urandom_range(0, 15)), d);
      end else if (op == 5) begin
        d = 16'($urandom);
        d[0] = 1'b1;
        d[1] = ($urandom_range(0, 7) == 0);
        wr(5'd16, d);
      end else if (op == 6) begin
        d = 16'($urandom);
        d[1:0] = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b00;
        wr(5'd16, d);
      end else if (op == 7) begin
        wr(5'($urandom_range(17, 31)), 16'($urandom));
      end else begin
        idle($urandom_range(0, 15));
      end
    end
    wr(5'd16, 16'h0002);

    // Async reset mid-play, then runs bounded by end marker and by step 15
    for (int i = 0; i < 16; i++) wr(5'(i), {4'(i), 12'd1});
    wr(5'd9, 16'h9000);
    wr(5'd16, 16'h00F1);
    idle(35);
    lit("pre_reset_idx", int'(idx0), 3);
    @(negedge CLK);
    #2 Reset = 1'b1;
    #1;
    lit("areset_acr0", int'(acr0), 0); lit("areset_play0", int'(ply0), 0);
    lit("areset_idx0", int'(idx0), 0); lit("areset_acr1", int'(acr1), 0);
    lit("areset_play1", int'(ply1), 0);
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    wr(5'd16, 16'h00F1);
    measure(110);
    lit("marker_done", dcnt[0], 1);
    lit("marker_done_idx", didx[0], 9);
    wait_idle();
    wr(5'd9, 16'h9001);
    wr(5'd16, 16'h00F1);
    measure(200);
    lit("step15_done", dcnt[0], 1);
    lit("step15_done_idx", didx[0], 15);
    wait_idle();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
